// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: direction encodings
// and the default sizing constants used by the counter and its prescaler.
package counter_pkg;

    // Direction encodings for the 'up' input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Default parameter values shared by every counter instance
    localparam int CNT_WIDTH_DEF    = 4;
    localparam int CNT_MODULUS_DEF  = 10;
    localparam int CNT_PRESCALE_DEF = 4;

    // Bit width needed to hold a count of 0..n-1, never less than one bit
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: counts en-high cycles and asserts 'step' on every
// PRESCALE-th one. Cleared by reset or clr, holds while en is low.
module cnt_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = CNT_PRESCALE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int PW = cnt_bits(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // Step fires combinationally on the en cycle that completes a group
    assign step = en && (cnt == LAST);

    // Count en-high cycles, restarting after each completed group
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with saturating parallel load, registered
// wrap pulse and combinational terminal-count flag.
// Optional feature: define MODCNT_PRESCALE_EN to make a step occur only on
// every PRESCALE-th en-high cycle.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = CNT_WIDTH_DEF,
    parameter int MODULUS  = CNT_MODULUS_DEF,
    parameter int PRESCALE = CNT_PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             step;
    logic             at_top;
    logic             at_bottom;
    logic             wrap;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_sat;

`ifdef MODCNT_PRESCALE_EN
    cnt_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (load),
        .en   (en),
        .step (step)
    );
`else
    // PRESCALE has no effect in this build; keep it referenced by name only
    localparam int unused_prescale = PRESCALE;
    assign step = en;
`endif

    // Next value for a step, wrapping explicitly at both ends of the range
    always_comb begin
        at_top    = (out == MAX_VAL);
        at_bottom = (out == '0);
        wrap      = (up == DIR_UP) ? at_top : at_bottom;
        if (up == DIR_UP) begin
            step_val = at_top ? '0 : out + 1'b1;
        end else begin
            step_val = at_bottom ? MAX_VAL : out - 1'b1;
        end
    end

    // Out-of-range load values saturate to the top of the count range
    assign load_sat = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

    // Terminal count depends on the current direction
    assign tc = wrap;

    // Count register with priority reset > load > step > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= '0;
            tick <= 1'b0;
        end else if (load) begin
            out  <= load_sat;
            tick <= 1'b0;
        end else if (step) begin
            out  <= step_val;
            tick <= wrap;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10).
// A driver applies directed then random stimulus and pushes the expected
// response from an arithmetic reference model; a monitor pops and compares.
module tb_updown_mod_counter;

    localparam int WIDTH    = 4;
    localparam int MODULUS  = 10;
    localparam int PRESCALE = 4;

    typedef struct {
        int out;
        bit tick;
        bit tc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tick;
    logic             tc;

    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    // Reference model state
    bit m_valid;
    int m_cnt;
    bit m_tick;
    int m_en_seen;

    updown_mod_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .out     (out),
        .tick    (tick),
        .tc      (tc)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the response predicted for the next edge
    task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l, input int lv);
        bit   do_step;
        exp_t x;
        @(negedge clk);
        reset    = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv[WIDTH-1:0];
        if (r) begin
            m_valid   = 1'b1;
            m_cnt     = 0;
            m_tick    = 1'b0;
            m_en_seen = 0;
        end else if (!m_valid) begin
            return;
        end else if (l) begin
            m_cnt     = (lv < MODULUS) ? lv : MODULUS - 1;
            m_tick    = 1'b0;
            m_en_seen = 0;
        end else if (e) begin
            m_en_seen++;
`ifdef MODCNT_PRESCALE_EN
            do_step = (m_en_seen % PRESCALE) == 0;
`else
            do_step = 1'b1;
`endif
            if (do_step) begin
                if (u) begin
                    m_tick = (m_cnt + 1 == MODULUS);
                    m_cnt  = (m_cnt + 1) % MODULUS;
                end else begin
                    m_tick = (m_cnt == 0);
                    m_cnt  = (m_cnt + MODULUS - 1) % MODULUS;
                end
            end else begin
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        x.out  = m_cnt;
        x.tick = m_tick;
        x.tc   = u ? (m_cnt == MODULUS - 1) : (m_cnt == 0);
        exp_q.push_back(x);
    endtask

    // Monitor: after every rising edge, check any pending expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput("out", int'(out), x.out);
                checkOutput("tick", int'(tick), int'(x.tick));
                checkOutput("tc", int'(tc), int'(x.tc));
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic
    initial begin
        int drain;
        tests_run    = 0;
        tests_failed = 0;
        m_valid      = 1'b0;
        m_cnt        = 0;
        m_tick       = 1'b0;
        m_en_seen    = 0;
        reset        = 1'b0;
        en           = 1'b0;
        up           = 1'b1;
        load         = 1'b0;
        load_val     = '0;

        // Count up through the wrap
        repeat (2) applyStimulus(1, 0, 1, 0, 0);
        repeat (12) applyStimulus(0, 1, 1, 0, 0);

        // Count down through the wrap
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0);

        // Loads with en high, including a saturating value
        applyStimulus(0, 1, 1, 1, 7);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 13);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 15);

        // Reset overrides a simultaneous load and enable
        applyStimulus(0, 0, 1, 1, 5);
        applyStimulus(1, 1, 1, 1, 3);
        applyStimulus(0, 0, 1, 0, 0);

        // Hold while en is low, then a direction flip at the top
        applyStimulus(0, 0, 1, 1, 4);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 9);
        applyStimulus(0, 1, 0, 0, 0);

        // Long enable run with a load in the middle
        repeat (8) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 2);
        repeat (6) applyStimulus(0, 1, 1, 0, 0);

        // Randomized traffic with occasional resets and loads
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 11) == 0,
                          int'($urandom_range(0, 15)));
        end

        // Let the monitor consume the remaining expectations, bounded
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            #2;
            drain++;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
